// File: rtl/y_mem_stage.sv
`default_nettype none
// =============================================================================
// Module  : y_mem_stage
// Brief   : Data-memory stage after yEX. Performs lw/sw on an internal word RAM
//           with configurable latency; registered valid/ready writeback packet.
// Revision: 1.0  initial release
// =============================================================================
module y_mem_stage #(
  parameter int AW      = 10,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] z,
  input  logic [31:0] rd2,
  input  logic [4:0]  rd_idx,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem2reg,
  input  logic        reg_write,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wd,
  output logic [4:0]  wb_idx,
  output logic        wb_we,
  output logic        err
);

  localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] lz_q, lz_d;
  logic [31:0] lrd2_q, lrd2_d;
  logic [4:0]  lidx_q, lidx_d;
  logic        lmr_q, lmr_d, lmw_q, lmw_d, lm2r_q, lm2r_d, lrw_q, lrw_d;

  logic        out_valid_q, out_valid_d;
  logic [31:0] wd_q, wd_d;
  logic [4:0]  wb_idx_q, wb_idx_d;
  logic        wb_we_q, wb_we_d;
  logic        err_q, err_d;

  logic [31:0] ram [1<<AW];
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_we;

  logic        out_free, accept, in_mem, l_illegal, load;
  logic [31:0] src_z;
  logic [4:0]  src_idx;
  logic        src_m2r, src_rw, src_ill;

  assign out_free  = ~out_valid_q | out_ready;
  assign in_ready  = (state_q == S_IDLE) & out_free & ~rst;
  assign accept    = in_valid & in_ready;
  assign in_mem    = mem_read | mem_write;
  assign l_illegal = ((lmr_q | lmw_q) & (lz_q[1:0] != 2'b00)) | (lmr_q & lmw_q);

  // Upper address bits are dropped, so accesses wrap modulo the RAM depth.
  assign ram_addr  = (state_q == S_IDLE) ? z[AW+1:2] : lz_q[AW+1:2];
  assign ram_rdata = ram[ram_addr];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lz_d        = lz_q;
    lrd2_d      = lrd2_q;
    lidx_d      = lidx_q;
    lmr_d       = lmr_q;
    lmw_d       = lmw_q;
    lm2r_d      = lm2r_q;
    lrw_d       = lrw_q;
    out_valid_d = out_valid_q;
    wd_d        = wd_q;
    wb_idx_d    = wb_idx_q;
    wb_we_d     = wb_we_q;
    err_d       = err_q;
    load        = 1'b0;
    ram_we      = 1'b0;
    src_z       = z;
    src_idx     = rd_idx;
    src_m2r     = mem2reg;
    src_rw      = reg_write;
    src_ill     = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_mem) begin
            lz_d    = z;
            lrd2_d  = rd2;
            lidx_d  = rd_idx;
            lmr_d   = mem_read;
            lmw_d   = mem_write;
            lm2r_d  = mem2reg;
            lrw_d   = reg_write;
            cnt_d   = c_cnt_init;
            state_d = S_ACCESS;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        src_z   = lz_q;
        src_idx = lidx_q;
        src_m2r = lm2r_q;
        src_rw  = lrw_q;
        src_ill = l_illegal;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (out_free) begin
          // Commit only when the packet can be written, so a stalled sw stays uncommitted.
          load    = 1'b1;
          ram_we  = lmw_q & ~l_illegal & ~rst;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      wd_d        = (src_m2r & ~src_ill) ? ram_rdata : src_z;
      wb_idx_d    = src_idx;
      wb_we_d     = src_rw & (src_idx != 5'd0) & ~src_ill;
      err_d       = src_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      lz_q        <= 32'd0;
      lrd2_q      <= 32'd0;
      lidx_q      <= 5'd0;
      lmr_q       <= 1'b0;
      lmw_q       <= 1'b0;
      lm2r_q      <= 1'b0;
      lrw_q       <= 1'b0;
      out_valid_q <= 1'b0;
      wd_q        <= 32'd0;
      wb_idx_q    <= 5'd0;
      wb_we_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lz_q        <= lz_d;
      lrd2_q      <= lrd2_d;
      lidx_q      <= lidx_d;
      lmr_q       <= lmr_d;
      lmw_q       <= lmw_d;
      lm2r_q      <= lm2r_d;
      lrw_q       <= lrw_d;
      out_valid_q <= out_valid_d;
      wd_q        <= wd_d;
      wb_idx_q    <= wb_idx_d;
      wb_we_q     <= wb_we_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= lrd2_q;
  end

  assign out_valid = out_valid_q;
  assign wd        = wd_q;
  assign wb_idx    = wb_idx_q;
  assign wb_we     = wb_we_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_y_mem_stage.sv
`default_nettype none
// =============================================================================
// Module  : tb_y_mem_stage
// Brief   : Self-checking bench: vector table, directed memory sequences and a
//           randomized run scored against a transaction-level reference model.
// Revision: 1.0  initial release
// =============================================================================
module tb_y_mem_stage;

  localparam int AW      = 10;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] z, rd2;
  logic [4:0]  rd_idx;
  logic        mem_read, mem_write, mem2reg, reg_write;
  logic        out_valid, out_ready;
  logic [31:0] wd;
  logic [4:0]  wb_idx;
  logic        wb_we, err;

  y_mem_stage #(.AW(AW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .rd2(rd2), .rd_idx(rd_idx), .mem_read(mem_read), .mem_write(mem_write),
    .mem2reg(mem2reg), .reg_write(reg_write), .out_valid(out_valid),
    .out_ready(out_ready), .wd(wd), .wb_idx(wb_idx), .wb_we(wb_we), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] wd;
    logic [4:0]  idx;
    logic        we;
    logic        err;
  } pkt_t;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  idx;
    logic        rw;
    logic [31:0] e_wd;
    logic [4:0]  e_idx;
    logic        e_we;
  } vec_t;

  logic [31:0] ref_ram [int];
  pkt_t        exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] zi, input logic [31:0] di,
                        input logic [4:0] ii, input logic mr, input logic mw,
                        input logic m2r, input logic rw);
    in_valid = v; z = zi; rd2 = di; rd_idx = ii;
    mem_read = mr; mem_write = mw; mem2reg = m2r; reg_write = rw;
  endtask

  // Issue one op with out_ready=1, return edges from accept edge to out_valid and the packet.
  task automatic mem_op(input logic [31:0] zi, input logic [31:0] di, input logic [4:0] ii,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        output int lat, output pkt_t p, output logic ready_seen);
    int guard = 0;
    ready_seen = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, zi, di, ii, mr, mw, m2r, rw);
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tick();
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) ready_seen = 1'b1;
      tick();
      lat++;
    end
    p.wd = wd; p.idx = wb_idx; p.we = wb_we; p.err = err;
    tick();
  endtask

  // Reference: whole-transaction semantics, applied in acceptance order.
  function automatic pkt_t model(input logic [31:0] zi, input logic [31:0] di, input logic [4:0] ii,
                                 input logic mr, input logic mw, input logic m2r, input logic rw);
    pkt_t p;
    int   w;
    logic ill;
    w   = int'(zi[AW+1:2]);
    ill = ((mr || mw) && zi[1:0] != 2'b00) || (mr && mw);
    p.wd  = zi;
    if (!ill && m2r && mr) p.wd = ref_ram.exists(w) ? ref_ram[w] : 32'hx;
    p.idx = ii;
    p.we  = rw && (ii != 0) && !ill;
    p.err = ill;
    if (mw && !ill) ref_ram[w] = di;
    return p;
  endfunction

  initial begin
    vec_t        vecs [6];
    int          lat;
    pkt_t        p;
    logic        rs;
    logic        bad;
    logic [31:0] pool [8];

    vecs[0] = '{32'h0000_000C, 5'd5,  1'b1, 32'h0000_000C, 5'd5,  1'b1};
    vecs[1] = '{32'hFFFF_0001, 5'd31, 1'b1, 32'hFFFF_0001, 5'd31, 1'b1};
    vecs[2] = '{32'h0000_1234, 5'd0,  1'b1, 32'h0000_1234, 5'd0,  1'b0};
    vecs[3] = '{32'h8000_0000, 5'd12, 1'b0, 32'h8000_0000, 5'd12, 1'b0};
    vecs[4] = '{32'h0000_002A, 5'd3,  1'b1, 32'h0000_002A, 5'd3,  1'b1};
    vecs[5] = '{32'h0000_0000, 5'd1,  1'b1, 32'h0000_0000, 5'd1,  1'b1};

    rst = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 32'h10, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    tick(); tick();
    rst = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_wb_idx", wb_idx, 5'd0);
    chk("rst_wb_we", wb_we, 1'b0);
    chk("rst_err", err, 1'b0);

    // Non-memory ops back to back: one packet per cycle, visible after the accept edge.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, vecs[i].z, 32'h0, vecs[i].idx, 1'b0, 1'b0, 1'b0, vecs[i].rw);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_wd", i), wd, vecs[i].e_wd);
      chk($sformatf("vec%0d_wb_idx", i), wb_idx, vecs[i].e_idx);
      chk($sformatf("vec%0d_wb_we", i), wb_we, vecs[i].e_we);
      chk($sformatf("vec%0d_err", i), err, 1'b0);
    end
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("drain_out_valid", out_valid, 1'b0);

    // sw then lw to the same word.
    mem_op(32'h28, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, p, rs);
    chk("sw_lat", lat, MEM_LAT);
    chk("sw_wb_we", p.we, 1'b0);
    chk("sw_err", p.err, 1'b0);
    mem_op(32'h28, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, lat, p, rs);
    chk("lw_lat", lat, MEM_LAT);
    chk("lw_ready_in_access", rs, 1'b0);
    chk("lw_wd", p.wd, 32'hDEADBEEF);
    chk("lw_wb_idx", p.idx, 5'd7);
    chk("lw_wb_we", p.we, 1'b1);

    // Misaligned and doubly-decoded accesses.
    mem_op(32'h2A, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, lat, p, rs);
    chk("mis_lat", lat, MEM_LAT);
    chk("mis_err", p.err, 1'b1);
    chk("mis_wb_we", p.we, 1'b0);
    chk("mis_wd", p.wd, 32'h2A);
    mem_op(32'h2A, 32'h11111111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, p, rs);
    chk("mis_sw_err", p.err, 1'b1);
    mem_op(32'h28, 32'h22222222, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, lat, p, rs);
    chk("rw_both_err", p.err, 1'b1);
    chk("rw_both_wd", p.wd, 32'h28);
    mem_op(32'h28, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, lat, p, rs);
    chk("mis_reread", p.wd, 32'hDEADBEEF);

    // Back-pressure: an rd=0 add is held while a sw waits upstream.
    out_ready = 1'b0;
    set_in(1'b1, 32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_accept", in_ready, 1'b1);
    tick();
    set_in(1'b1, 32'h28, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_rd0_wb_we", wb_we, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
      chk($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      chk($sformatf("bp%0d_wd", i), wd, 32'h55);
      chk($sformatf("bp%0d_wb_idx", i), wb_idx, 5'd0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    tick();
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_drained", out_valid, 1'b0);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    chk("bp_sw_lat", lat, MEM_LAT);
    tick();
    mem_op(32'h28, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, lat, p, rs);
    chk("bp_lw_wd", p.wd, 32'hCAFEF00D);

    // Address wrap, then a sw aborted by reset mid-access.
    mem_op((32'h1 << (AW+2)) | 32'h4, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, p, rs);
    mem_op(32'h4, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, lat, p, rs);
    chk("wrap_lw_wd", p.wd, 32'h12345678);
    set_in(1'b1, 32'h4, 32'hBADBAD00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    set_in(1'b1, 32'h40, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready0", in_ready, 1'b0);
    tick();
    @(negedge clk);
    chk("abort_rst_ready1", in_ready, 1'b0);
    tick();
    rst = 1'b0;
    set_in(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_wd", wd, 32'd0);
    chk("abort_wb_we", wb_we, 1'b0);
    @(negedge clk);
    chk("abort_ready_after", in_ready, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (out_valid) bad = 1'b1; end
    chk("abort_no_packet", bad, 1'b0);
    mem_op(32'h4, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, lat, p, rs);
    chk("abort_old_word", p.wd, 32'h12345678);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 8; k++) pool[k] = 32'((16 + k * 37) % (1 << AW));
    begin
      logic        have;
      logic        stall;
      pkt_t        held;
      int          txn;
      logic [31:0] tz, td;
      logic [4:0]  ti;
      logic        tmr, tmw, tm2r, trw;
      have = 1'b0; stall = 1'b0; txn = 0;
      tz = 0; td = 0; ti = 0; tmr = 0; tmw = 0; tm2r = 0; trw = 0;
      held = '{32'd0, 5'd0, 1'b0, 1'b0};
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (!have) begin
          if (txn < 8 || $urandom_range(0, 3) != 0) begin
            int kind;
            int slot;
            kind = (txn < 8) ? 3 : int'($urandom_range(0, 9));
            slot = (txn < 8) ? txn : int'($urandom_range(0, 7));
            tz = $urandom;
            tz[AW+1:2] = pool[slot][AW-1:0];
            tz[1:0] = 2'b00;
            td = $urandom; ti = 5'($urandom); trw = 1'($urandom);
            tmr = 0; tmw = 0; tm2r = 0;
            if (kind <= 2) tz = $urandom;
            else if (kind <= 5) tmw = 1;
            else if (kind <= 8) begin tmr = 1; tm2r = 1; end
            else begin
              tmr = 1'($urandom); tmw = ~tmr | 1'($urandom); tm2r = 1'($urandom);
              if (tmr && tmw) tz[1:0] = 2'($urandom);
              else tz[1:0] = 2'($urandom_range(1, 3));
            end
            have = 1'b1;
            txn++;
            set_in(1'b1, tz, td, ti, tmr, tmw, tm2r, trw);
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (stall) begin
          chk("rnd_hold_valid", out_valid, 1'b1);
          chk("rnd_hold_wd", wd, held.wd);
          chk("rnd_hold_idx", wb_idx, held.idx);
          chk("rnd_hold_we", wb_we, held.we);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rnd_spurious: actual=packet required=none wd=0x%08h", wd);
          end else begin
            pkt_t e;
            e = exp_q.pop_front();
            chk("rnd_wd", wd, e.wd);
            chk("rnd_idx", wb_idx, e.idx);
            chk("rnd_we", wb_we, e.we);
            chk("rnd_err", err, e.err);
          end
        end
        stall = out_valid && !out_ready;
        held = '{wd, wb_idx, wb_we, err};
        if (in_valid && in_ready) begin
          exp_q.push_back(model(tz, td, ti, tmr, tmw, tm2r, trw));
          have = 1'b0;
        end
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (have) begin
        @(negedge clk);
        if (in_ready) exp_q.push_back(model(tz, td, ti, tmr, tmw, tm2r, trw));
        tick();
      end
      for (int g = 0; g < 100 && exp_q.size() > 0; g++) begin
        @(negedge clk);
        if (out_valid) begin
          pkt_t e;
          e = exp_q.pop_front();
          chk("drain_wd", wd, e.wd);
          chk("drain_we", wb_we, e.we);
          chk("drain_err", err, e.err);
        end
        tick();
      end
      chk("rnd_queue_empty", exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
